scr1_pipe_mprf_wb: RTL and testbench
====================================

// Module: scr1_pipe_mprf_wb
// PURPOSE
//  EXU-side write/read front end of the MPRF: merges ALU and LSU (load) write-back into the single MPRF
//  write port, tracks outstanding load destinations in a scoreboard, raises rs1/rs2/rd hazards, and drives
//  registered write requests to the MPRF. Sits between EXU/LSU and scr1_pipe_mprf.
// PARAMETERS
//  LD_PEND_DEPTH   2   max outstanding loads; in-order rd-address FIFO depth (1..4)
// PORTS
//  rst_n                 in   1          async active-low reset
//  clk                   in   1          clock
//  exu2wb_ld_issue_i     in   1          load issued to LSU this cycle
//  exu2wb_ld_rd_addr_i   in   AW         load destination register
//  wb2exu_ld_issue_rdy_o out  1          load may issue
//  lsu2wb_rsp_vd_i       in   1          load response valid (in issue order)
//  lsu2wb_rsp_err_i      in   1          load faulted: no register write
//  lsu2wb_rsp_data_i     in   XLEN       load data
//  exu2wb_alu_req_i      in   1          ALU result write request
//  exu2wb_alu_rd_addr_i  in   AW         ALU destination
//  exu2wb_alu_rd_data_i  in   XLEN       ALU result
//  wb2exu_alu_rdy_o      out  1          ALU write accepted this cycle
//  exu2wb_rs1_addr_i     in   AW         rs1 read address (forwarded to MPRF unchanged as exu2mprf_rs1_addr_o)
//  exu2wb_rs2_addr_i     in   AW         rs2 read address (-> exu2mprf_rs2_addr_o)
//  exu2mprf_rs1_addr_o / exu2mprf_rs2_addr_o  out AW   MPRF read addresses
//  mprf2exu_rs1_data_i / mprf2exu_rs2_data_i  in  XLEN MPRF read data
//  wb2exu_rs1_data_o / wb2exu_rs2_data_o      out XLEN operand data to EXU
//  wb2exu_rs1_hzd_o / wb2exu_rs2_hzd_o        out 1    operand not yet available: EXU stalls
//  exu2mprf_w_req_o      out  1          MPRF write request (registered)
//  exu2mprf_rd_addr_o    out  AW         MPRF write address (registered)
//  exu2mprf_rd_data_o    out  XLEN       MPRF write data (registered)
//  (AW = `SCR1_MPRF_AWIDTH, XLEN = `SCR1_XLEN)
// BEHAVIOUR
//  - Reset: scoreboard all 0, FIFO empty, w_req_o=0, rd_addr_o=0, rd_data_o=0; ld_issue_rdy_o=1, alu_rdy_o=1.
//  - Scoreboard pend[1:SIZE-1]: set on accepted load with rd!=0; cleared when that load's response
//    (FIFO head) is consumed, err or not. rd=0 loads occupy a FIFO entry but set no bit.
//  - ld_issue_rdy_o = (~full | rsp_vd) & ~(rd!=0 & pend[rd]). Issue while not ready: ignored.
//  - Response: pops FIFO head; write candidate iff ~err & head_rd!=0. Response with FIFO empty: ignored.
//  - Write select: LSU candidate has priority. alu_rdy_o = ~lsu_candidate & ~(alu_rd!=0 & pend[alu_rd]).
//    Accepted ALU write with rd=0: consumed, no MPRF write.
//  - Write stage: selected write registered; w_req_o valid exactly 1 cycle after acceptance; MPRF updates on
//    the following edge. Non-selected cycle: w_req_o=0, addr/data hold.
//  - Same-cycle issue+response: pop and push both occur; count unchanged; bit cleared for head, set for new.
//  - rsN_hzd_o = rsN!=0 & (pend[rsN] | stage_hit), stage_hit defined under CONFIGURATION. rsN=0: data 0
//    from MPRF, never hazard.
//  - Hazard is combinational in issue cycle; deasserts the cycle after the response is consumed (bypass on).
//  - Reset mid-operation: outstanding loads forgotten; later LSU responses ignored (FIFO empty).
//  - SVA (SCR1_TRGT_SIMULATION): response with empty FIFO; FIFO overflow; X on w_req_o.
// CONFIGURATION
//  SCR1_MPRF_WB_BYPASS_EN defined: stage_hit=0; wb2exu_rsN_data_o = (w_req_o & rd_addr_o==rsN & rsN!=0)
//    ? rd_data_o : mprf2exu_rsN_data_i. Zero-stall read after a write.
//  Undefined: data passes straight from MPRF; stage_hit = w_req_o & rd_addr_o==rsN; one extra stall cycle
//    per read-after-write within one cycle of the write stage.
// TESTING
//  1 Reset mid-load: issue ld x5, rst_n low 1 cycle, then response -> no write, pend[5]=0, rs1=x5 hzd=0.
//  2 ALU x3=0xDEADBEEF cyc0, read x3 cyc1 -> w_req_o=1 addr 3 cyc1; BYPASS_EN: data 0xDEADBEEF hzd=0;
//    else hzd=1 cyc1, 0xDEADBEEF from MPRF cyc2.
//  3 ld x7 issued, rs2=x7 -> hzd=1 until response 0x12345678 consumed; then w_req_o addr 7 data 0x12345678.
//  4 LSU rsp (x9,0xA) and ALU req (x4,0xB) same cycle -> alu_rdy_o=0, x9 written; ALU x4 written next cycle.
//  5 Depth=2: ld x1, ld x2, third ld x6 -> rdy=0; rsp for x1 same cycle as x6 issue -> x6 accepted,
//    later rsp err -> x2 cleared, no write; ld x1 again while pend[1] -> rdy=0.
//  6 ld x0 then ALU x0 -> FIFO entry consumed, no w_req_o, no hazard ever raised.

Source files
------------

// File: rtl/scr1_pipe_mprf_wb_if.sv
// rtl/scr1_pipe_mprf_wb_if.sv - EXU/LSU/MPRF signal bundle around the MPRF write-back front end
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif
`ifndef SCR1_MPRF_AWIDTH
`define SCR1_MPRF_AWIDTH 5
`endif

interface scr1_pipe_mprf_wb_if;
  logic                          exu2wb_ld_issue_i;
  logic [`SCR1_MPRF_AWIDTH-1:0]  exu2wb_ld_rd_addr_i;
  logic                          wb2exu_ld_issue_rdy_o;
  logic                          lsu2wb_rsp_vd_i;
  logic                          lsu2wb_rsp_err_i;
  logic [`SCR1_XLEN-1:0]         lsu2wb_rsp_data_i;
  logic                          exu2wb_alu_req_i;
  logic [`SCR1_MPRF_AWIDTH-1:0]  exu2wb_alu_rd_addr_i;
  logic [`SCR1_XLEN-1:0]         exu2wb_alu_rd_data_i;
  logic                          wb2exu_alu_rdy_o;
  logic [`SCR1_MPRF_AWIDTH-1:0]  exu2wb_rs1_addr_i;
  logic [`SCR1_MPRF_AWIDTH-1:0]  exu2wb_rs2_addr_i;
  logic [`SCR1_MPRF_AWIDTH-1:0]  exu2mprf_rs1_addr_o;
  logic [`SCR1_MPRF_AWIDTH-1:0]  exu2mprf_rs2_addr_o;
  logic [`SCR1_XLEN-1:0]         mprf2exu_rs1_data_i;
  logic [`SCR1_XLEN-1:0]         mprf2exu_rs2_data_i;
  logic [`SCR1_XLEN-1:0]         wb2exu_rs1_data_o;
  logic [`SCR1_XLEN-1:0]         wb2exu_rs2_data_o;
  logic                          wb2exu_rs1_hzd_o;
  logic                          wb2exu_rs2_hzd_o;
  logic                          exu2mprf_w_req_o;
  logic [`SCR1_MPRF_AWIDTH-1:0]  exu2mprf_rd_addr_o;
  logic [`SCR1_XLEN-1:0]         exu2mprf_rd_data_o;

  // Write-back block side
  modport slave (
    input  exu2wb_ld_issue_i, exu2wb_ld_rd_addr_i,
    input  lsu2wb_rsp_vd_i, lsu2wb_rsp_err_i, lsu2wb_rsp_data_i,
    input  exu2wb_alu_req_i, exu2wb_alu_rd_addr_i, exu2wb_alu_rd_data_i,
    input  exu2wb_rs1_addr_i, exu2wb_rs2_addr_i,
    input  mprf2exu_rs1_data_i, mprf2exu_rs2_data_i,
    output wb2exu_ld_issue_rdy_o, wb2exu_alu_rdy_o,
    output exu2mprf_rs1_addr_o, exu2mprf_rs2_addr_o,
    output wb2exu_rs1_data_o, wb2exu_rs2_data_o,
    output wb2exu_rs1_hzd_o, wb2exu_rs2_hzd_o,
    output exu2mprf_w_req_o, exu2mprf_rd_addr_o, exu2mprf_rd_data_o
  );

  // EXU/LSU/MPRF environment side
  modport master (
    output exu2wb_ld_issue_i, exu2wb_ld_rd_addr_i,
    output lsu2wb_rsp_vd_i, lsu2wb_rsp_err_i, lsu2wb_rsp_data_i,
    output exu2wb_alu_req_i, exu2wb_alu_rd_addr_i, exu2wb_alu_rd_data_i,
    output exu2wb_rs1_addr_i, exu2wb_rs2_addr_i,
    output mprf2exu_rs1_data_i, mprf2exu_rs2_data_i,
    input  wb2exu_ld_issue_rdy_o, wb2exu_alu_rdy_o,
    input  exu2mprf_rs1_addr_o, exu2mprf_rs2_addr_o,
    input  wb2exu_rs1_data_o, wb2exu_rs2_data_o,
    input  wb2exu_rs1_hzd_o, wb2exu_rs2_hzd_o,
    input  exu2mprf_w_req_o, exu2mprf_rd_addr_o, exu2mprf_rd_data_o
  );
endinterface

// File: rtl/scr1_pipe_mprf_wb.sv
// rtl/scr1_pipe_mprf_wb.sv - MPRF write-back merge, load scoreboard and operand hazards
// Optional read bypass from the write stage: SCR1_MPRF_WB_BYPASS_EN.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif
`ifndef SCR1_MPRF_AWIDTH
`define SCR1_MPRF_AWIDTH 5
`endif

module scr1_pipe_mprf_wb #(
  parameter int LD_PEND_DEPTH = 2
) (
  input  logic                 rst_n,
  input  logic                 clk,
  scr1_pipe_mprf_wb_if.slave   wb
);

  localparam int AW   = `SCR1_MPRF_AWIDTH;
  localparam int XLEN = `SCR1_XLEN;
  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(LD_PEND_DEPTH + 1);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [AW-1:0]   fifo_q [LD_PEND_DEPTH];
  logic [AW-1:0]   fifo_d [LD_PEND_DEPTH];
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   push_idx;

  logic            fifo_empty;
  logic            fifo_full;
  logic [AW-1:0]   head_rd;
  logic [AW-1:0]   ld_rd;
  logic [AW-1:0]   alu_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;

  logic            ld_rdy;
  logic            ld_acc;
  logic            rsp_pop;
  logic            lsu_cand;
  logic            alu_rdy;
  logic            alu_wr;
  logic            wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  logic            w_req_q;
  logic [AW-1:0]   w_addr_q;
  logic [XLEN-1:0] w_data_q;

  logic            stage_hit1;
  logic            stage_hit2;

  assign ld_rd      = wb.exu2wb_ld_rd_addr_i;
  assign alu_rd     = wb.exu2wb_alu_rd_addr_i;
  assign rs1        = wb.exu2wb_rs1_addr_i;
  assign rs2        = wb.exu2wb_rs2_addr_i;
  assign head_rd    = fifo_q[0];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(LD_PEND_DEPTH));

  // A response arriving in a full cycle frees the head slot for a same-cycle issue.
  assign ld_rdy  = (~fifo_full | wb.lsu2wb_rsp_vd_i) & ~((ld_rd != '0) & pend_q[ld_rd]);
  assign ld_acc  = wb.exu2wb_ld_issue_i & ld_rdy;
  assign rsp_pop = wb.lsu2wb_rsp_vd_i & ~fifo_empty;

  assign lsu_cand = rsp_pop & ~wb.lsu2wb_rsp_err_i & (head_rd != '0);
  assign alu_rdy  = ~lsu_cand & ~((alu_rd != '0) & pend_q[alu_rd]);
  assign alu_wr   = wb.exu2wb_alu_req_i & alu_rdy & (alu_rd != '0);

  assign wr_sel  = lsu_cand | alu_wr;
  assign wr_addr = lsu_cand ? head_rd : alu_rd;
  assign wr_data = lsu_cand ? wb.lsu2wb_rsp_data_i : wb.exu2wb_alu_rd_data_i;

  assign push_idx = rsp_pop ? (cnt_q - CW'(1)) : cnt_q;

  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (rsp_pop) begin
      for (int i = 0; i < LD_PEND_DEPTH - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
      cnt_d = cnt_q - CW'(1);
    end
    if (ld_acc) begin
      for (int i = 0; i < LD_PEND_DEPTH; i++) begin
        if (push_idx == CW'(i)) begin
          fifo_d[i] = ld_rd;
        end
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  // Head and new rd can never coincide: a pending rd blocks its own reissue.
  always_comb begin
    pend_d = pend_q;
    if (rsp_pop) begin
      pend_d[head_rd] = 1'b0;
    end
    if (ld_acc && (ld_rd != '0)) begin
      pend_d[ld_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < LD_PEND_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      fifo_q <= fifo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_req_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_req_q <= wr_sel;
      if (wr_sel) begin
        w_addr_q <= wr_addr;
        w_data_q <= wr_data;
      end
    end
  end

`ifdef SCR1_MPRF_WB_BYPASS_EN
  assign stage_hit1 = 1'b0;
  assign stage_hit2 = 1'b0;
  assign wb.wb2exu_rs1_data_o = (w_req_q & (w_addr_q == rs1) & (rs1 != '0))
                                ? w_data_q : wb.mprf2exu_rs1_data_i;
  assign wb.wb2exu_rs2_data_o = (w_req_q & (w_addr_q == rs2) & (rs2 != '0))
                                ? w_data_q : wb.mprf2exu_rs2_data_i;
`else
  // Without bypass the operand waits until the MPRF has absorbed the write.
  assign stage_hit1 = w_req_q & (w_addr_q == rs1);
  assign stage_hit2 = w_req_q & (w_addr_q == rs2);
  assign wb.wb2exu_rs1_data_o = wb.mprf2exu_rs1_data_i;
  assign wb.wb2exu_rs2_data_o = wb.mprf2exu_rs2_data_i;
`endif

  assign wb.wb2exu_rs1_hzd_o = (rs1 != '0) & (pend_q[rs1] | stage_hit1);
  assign wb.wb2exu_rs2_hzd_o = (rs2 != '0) & (pend_q[rs2] | stage_hit2);

  assign wb.exu2mprf_rs1_addr_o   = rs1;
  assign wb.exu2mprf_rs2_addr_o   = rs2;
  assign wb.wb2exu_ld_issue_rdy_o = ld_rdy;
  assign wb.wb2exu_alu_rdy_o      = alu_rdy;
  assign wb.exu2mprf_w_req_o      = w_req_q;
  assign wb.exu2mprf_rd_addr_o    = w_addr_q;
  assign wb.exu2mprf_rd_data_o    = w_data_q;

`ifdef SCR1_TRGT_SIMULATION
  a_rsp_fifo_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb.lsu2wb_rsp_vd_i & fifo_empty));
  a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(ld_acc & fifo_full & ~rsp_pop));
  a_w_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(w_req_q));
`endif

endmodule

// File: tb/tb_scr1_pipe_mprf_wb.sv
// tb/tb_scr1_pipe_mprf_wb.sv - directed scoreboard bench for scr1_pipe_mprf_wb
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif
`ifndef SCR1_MPRF_AWIDTH
`define SCR1_MPRF_AWIDTH 5
`endif

module tb_scr1_pipe_mprf_wb;
  localparam int AW   = `SCR1_MPRF_AWIDTH;
  localparam int XLEN = `SCR1_XLEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [AW+XLEN-1:0] sb [$];
  logic [AW+XLEN-1:0] mon_e;
  logic [XLEN-1:0]    mem [1<<AW];

  always #5 clk = ~clk;

  scr1_pipe_mprf_wb_if bus ();

  scr1_pipe_mprf_wb #(.LD_PEND_DEPTH(2)) dut (
    .rst_n (rst_n),
    .clk   (clk),
    .wb    (bus)
  );

  // Register file model standing in for scr1_pipe_mprf
  always @(posedge clk) begin
    if (!rst_n && n_tests == 0) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (bus.exu2mprf_w_req_o === 1'b1) begin
      mem[bus.exu2mprf_rd_addr_o] <= bus.exu2mprf_rd_data_o;
    end
  end
  assign bus.mprf2exu_rs1_data_i = (bus.exu2mprf_rs1_addr_o == '0) ? '0 : mem[bus.exu2mprf_rs1_addr_o];
  assign bus.mprf2exu_rs2_data_i = (bus.exu2mprf_rs2_addr_o == '0) ? '0 : mem[bus.exu2mprf_rs2_addr_o];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input int a, input logic [XLEN-1:0] d);
    logic [AW-1:0] aa;
    aa = a[AW-1:0];
    sb.push_back({aa, d});
  endtask

  task automatic clear();
    bus.exu2wb_ld_issue_i    = 1'b0;
    bus.exu2wb_ld_rd_addr_i  = '0;
    bus.lsu2wb_rsp_vd_i      = 1'b0;
    bus.lsu2wb_rsp_err_i     = 1'b0;
    bus.lsu2wb_rsp_data_i    = '0;
    bus.exu2wb_alu_req_i     = 1'b0;
    bus.exu2wb_alu_rd_addr_i = '0;
    bus.exu2wb_alu_rd_data_i = '0;
    bus.exu2wb_rs1_addr_i    = '0;
    bus.exu2wb_rs2_addr_i    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input int rd);
    bus.exu2wb_ld_issue_i   = 1'b1;
    bus.exu2wb_ld_rd_addr_i = rd[AW-1:0];
  endtask

  task automatic rsp(input logic err, input logic [XLEN-1:0] d);
    bus.lsu2wb_rsp_vd_i   = 1'b1;
    bus.lsu2wb_rsp_err_i  = err;
    bus.lsu2wb_rsp_data_i = d;
  endtask

  task automatic alu(input int rd, input logic [XLEN-1:0] d);
    bus.exu2wb_alu_req_i     = 1'b1;
    bus.exu2wb_alu_rd_addr_i = rd[AW-1:0];
    bus.exu2wb_alu_rd_data_i = d;
  endtask

  // Scoreboard: every registered write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && bus.exu2mprf_w_req_o !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("wreq_unexpected", 64'(bus.exu2mprf_w_req_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wreq", 64'(bus.exu2mprf_w_req_o), 64'd1);
        chk("wb_addr", 64'(bus.exu2mprf_rd_addr_o), 64'(mon_e[AW+XLEN-1:XLEN]));
        chk("wb_data", 64'(bus.exu2mprf_rd_data_o), 64'(mon_e[XLEN-1:0]));
      end
    end
  end

  initial begin
    clear();
    rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_wreq", 64'(bus.exu2mprf_w_req_o), 64'd0);
    chk("rst_addr", 64'(bus.exu2mprf_rd_addr_o), 64'd0);
    chk("rst_data", 64'(bus.exu2mprf_rd_data_o), 64'd0);
    chk("rst_ld_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd1);
    chk("rst_alu_rdy", 64'(bus.wb2exu_alu_rdy_o), 64'd1);
    step(); rst_n = 1'b1;

    // 1: reset while a load is outstanding
    ld(5);
    @(negedge clk); chk("t1_ld_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd1);
    step(); clear(); bus.exu2wb_rs1_addr_i = 5;
    @(negedge clk); chk("t1_pend_set", 64'(bus.wb2exu_rs1_hzd_o), 64'd1);
    step(); clear(); rst_n = 1'b0;
    step(); rst_n = 1'b1; rsp(1'b0, 32'h5555_0000); bus.exu2wb_rs1_addr_i = 5;
    @(negedge clk); chk("t1_hzd_after_rst", 64'(bus.wb2exu_rs1_hzd_o), 64'd0);
    step(); clear(); bus.exu2wb_rs1_addr_i = 5;
    @(negedge clk);
    chk("t1_no_wreq", 64'(bus.exu2mprf_w_req_o), 64'd0);
    chk("t1_hzd_idle", 64'(bus.wb2exu_rs1_hzd_o), 64'd0);

    // 2: ALU write followed by a read of the same register
    step(); clear(); alu(3, 32'hDEAD_BEEF); exp_wr(3, 32'hDEAD_BEEF);
    @(negedge clk); chk("t2_alu_rdy", 64'(bus.wb2exu_alu_rdy_o), 64'd1);
    step(); clear(); bus.exu2wb_rs1_addr_i = 3;
    @(negedge clk);
    chk("t2_wreq_addr", 64'(bus.exu2mprf_rd_addr_o), 64'd3);
`ifdef SCR1_MPRF_WB_BYPASS_EN
    chk("t2_hzd_c1", 64'(bus.wb2exu_rs1_hzd_o), 64'd0);
    chk("t2_data_c1", 64'(bus.wb2exu_rs1_data_o), 64'hDEAD_BEEF);
`else
    chk("t2_hzd_c1", 64'(bus.wb2exu_rs1_hzd_o), 64'd1);
`endif
    step(); clear(); bus.exu2wb_rs1_addr_i = 3;
    @(negedge clk);
    chk("t2_hzd_c2", 64'(bus.wb2exu_rs1_hzd_o), 64'd0);
    chk("t2_data_c2", 64'(bus.wb2exu_rs1_data_o), 64'hDEAD_BEEF);

    // 3: load-use hazard on rs2
    step(); clear(); ld(7); bus.exu2wb_rs2_addr_i = 7;
    @(negedge clk); chk("t3_ld_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd1);
    step(); clear(); bus.exu2wb_rs2_addr_i = 7;
    @(negedge clk); chk("t3_hzd_wait", 64'(bus.wb2exu_rs2_hzd_o), 64'd1);
    step(); clear(); bus.exu2wb_rs2_addr_i = 7; rsp(1'b0, 32'h1234_5678); exp_wr(7, 32'h1234_5678);
    @(negedge clk); chk("t3_hzd_rsp", 64'(bus.wb2exu_rs2_hzd_o), 64'd1);
    step(); clear(); bus.exu2wb_rs2_addr_i = 7;
    @(negedge clk);
`ifdef SCR1_MPRF_WB_BYPASS_EN
    chk("t3_hzd_stage", 64'(bus.wb2exu_rs2_hzd_o), 64'd0);
    chk("t3_data_stage", 64'(bus.wb2exu_rs2_data_o), 64'h1234_5678);
`else
    chk("t3_hzd_stage", 64'(bus.wb2exu_rs2_hzd_o), 64'd1);
`endif
    step(); clear(); bus.exu2wb_rs2_addr_i = 7;
    @(negedge clk);
    chk("t3_hzd_done", 64'(bus.wb2exu_rs2_hzd_o), 64'd0);
    chk("t3_data_done", 64'(bus.wb2exu_rs2_data_o), 64'h1234_5678);

    // 4: LSU and ALU write in the same cycle
    step(); clear(); ld(9);
    step(); clear(); rsp(1'b0, 32'h0000_000A); alu(4, 32'h0000_000B); exp_wr(9, 32'h0000_000A);
    @(negedge clk); chk("t4_alu_blocked", 64'(bus.wb2exu_alu_rdy_o), 64'd0);
    step(); clear(); alu(4, 32'h0000_000B); exp_wr(4, 32'h0000_000B);
    @(negedge clk);
    chk("t4_alu_rdy", 64'(bus.wb2exu_alu_rdy_o), 64'd1);
    chk("t4_first_addr", 64'(bus.exu2mprf_rd_addr_o), 64'd9);
    step(); clear();
    @(negedge clk); chk("t4_second_addr", 64'(bus.exu2mprf_rd_addr_o), 64'd4);

    // 5: FIFO full, issue alongside response, faulted load, pending-rd reissue
    step(); clear(); ld(1);
    @(negedge clk); chk("t5_ld1_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd1);
    step(); clear(); ld(2);
    @(negedge clk); chk("t5_ld2_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd1);
    step(); clear(); ld(6);
    @(negedge clk); chk("t5_full_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd0);
    step(); clear(); ld(6); rsp(1'b0, 32'h0000_0011); exp_wr(1, 32'h0000_0011);
    @(negedge clk); chk("t5_full_rsp_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd1);
    step(); clear(); rsp(1'b1, 32'h0000_00EE); bus.exu2wb_rs1_addr_i = 2; bus.exu2wb_rs2_addr_i = 6;
    @(negedge clk);
    chk("t5_x2_pend", 64'(bus.wb2exu_rs1_hzd_o), 64'd1);
    chk("t5_x6_pend", 64'(bus.wb2exu_rs2_hzd_o), 64'd1);
    step(); clear(); bus.exu2wb_rs1_addr_i = 2;
    @(negedge clk);
    chk("t5_err_no_wreq", 64'(bus.exu2mprf_w_req_o), 64'd0);
    chk("t5_x2_cleared", 64'(bus.wb2exu_rs1_hzd_o), 64'd0);
    step(); clear(); rsp(1'b0, 32'h0000_0066); exp_wr(6, 32'h0000_0066);
    step(); clear(); ld(1);
    @(negedge clk); chk("t5_ld1_again_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd1);
    step(); clear(); ld(1); bus.exu2wb_alu_rd_addr_i = 1;
    @(negedge clk);
    chk("t5_pend_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd0);
    chk("t5_pend_alu_rdy", 64'(bus.wb2exu_alu_rdy_o), 64'd0);
    step(); clear(); rsp(1'b0, 32'h0000_0077); exp_wr(1, 32'h0000_0077);
    step(); clear();

    // 6: x0 destinations never write and never raise a hazard
    step(); clear(); ld(0);
    @(negedge clk);
    chk("t6_ld0_rdy", 64'(bus.wb2exu_ld_issue_rdy_o), 64'd1);
    chk("t6_hzd_x0_a", 64'(bus.wb2exu_rs1_hzd_o), 64'd0);
    step(); clear(); rsp(1'b0, 32'h0000_0099);
    @(negedge clk);
    chk("t6_hzd_x0_b", 64'(bus.wb2exu_rs1_hzd_o), 64'd0);
    chk("t6_alu_rdy_rsp", 64'(bus.wb2exu_alu_rdy_o), 64'd1);
    step(); clear(); alu(0, 32'h0000_0042);
    @(negedge clk);
    chk("t6_alu0_rdy", 64'(bus.wb2exu_alu_rdy_o), 64'd1);
    chk("t6_no_wreq_a", 64'(bus.exu2mprf_w_req_o), 64'd0);
    chk("t6_data_x0", 64'(bus.wb2exu_rs1_data_o), 64'd0);
    step(); clear();
    @(negedge clk); chk("t6_no_wreq_b", 64'(bus.exu2mprf_w_req_o), 64'd0);

    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
